// File: rtl/rvsteel_uart_bus_bridge.sv
// UART-driven IO bus initiator. The host sends 'W' addr[4] data[4] or 'R' addr[4]
// (multi-byte fields MSB first, 8N1 framing). The bridge runs one 32-bit bus
// transaction and replies with ACK, NAK or the four read-data bytes.
module rvsteel_uart_bus_bridge #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned UART_BAUD_RATE  = 9600,
  parameter int unsigned BUS_TIMEOUT     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [31:0] rw_address,
  input  logic [31:0] read_data,
  output logic        read_request,
  input  logic        read_response,
  output logic [31:0] write_data,
  output logic [3:0]  write_strobe,
  output logic        write_request,
  input  logic        write_response,
  output logic        busy
);

  localparam logic [31:0] CPB        = 32'(CLOCK_FREQUENCY / UART_BAUD_RATE);
  localparam logic [31:0] HALF_CPB   = CPB / 32'd2;
  localparam logic [31:0] IB_TIMEOUT = CPB * 32'd160;
  localparam logic [31:0] BUS_TO     = 32'(BUS_TIMEOUT);
  localparam logic [7:0]  CMD_W = 8'h57;
  localparam logic [7:0]  CMD_R = 8'h52;
  localparam logic [7:0]  ACK   = 8'h06;
  localparam logic [7:0]  NAK   = 8'h15;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {S_IDLE, S_GET_ADDR, S_GET_DATA, S_BUS_WRITE, S_BUS_READ, S_SEND} state_e;

  // ---------------------------------------------------------------- receiver
  logic        rx_meta_q, rx_sync_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [31:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_valid_q, rx_valid_d;

  // Receiver state register plus two-flop synchroniser on the raw line.
  // NOTE: sequential blocks use <= so every flop samples pre-edge values; = here would chain the two sync stages into one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Receiver next state: glitch check at half a bit, then sample mid-bit.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 32'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_CPB - 32'd1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == CPB - 32'd1) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == CPB - 32'd1) begin
        rx_valid_d = rx_sync_q;  // a low stop bit is a framing error: drop the byte
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ------------------------------------------------------------- transmitter
  logic        tx_q, tx_busy_q, tx_start;
  logic [8:0]  tx_shift_q;
  logic [3:0]  tx_bit_q;
  logic [31:0] tx_cnt_q;
  logic [7:0]  tx_byte;

  // Transmitter: start bit, 8 data bits LSB first, stop bit; idle again right after stop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
    end else if (!tx_busy_q) begin
      if (tx_start) begin
        tx_busy_q  <= 1'b1;
        tx_q       <= 1'b0;
        tx_shift_q <= {1'b1, tx_byte};
        tx_bit_q   <= '0;
        tx_cnt_q   <= '0;
      end
    end else if (tx_cnt_q == CPB - 32'd1) begin
      tx_cnt_q <= '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_q <= 1'b0;
      end else begin
        tx_q       <= tx_shift_q[0];
        tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        tx_bit_q   <= tx_bit_q + 4'd1;
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + 32'd1;
    end
  end

  // --------------------------------------------------------- command engine
  state_e      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, send_data_q, send_data_d;
  logic        rreq_q, rreq_d, wreq_q, wreq_d;
  logic [3:0]  strb_q, strb_d;
  logic [2:0]  send_cnt_q, send_cnt_d;

  // Command engine state and registered bus outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= '0;
      timer_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      send_data_q <= '0;
      rreq_q      <= 1'b0;
      wreq_q      <= 1'b0;
      strb_q      <= '0;
      send_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      byte_cnt_q  <= byte_cnt_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      send_data_q <= send_data_d;
      rreq_q      <= rreq_d;
      wreq_q      <= wreq_d;
      strb_q      <= strb_d;
      send_cnt_q  <= send_cnt_d;
    end
  end

  // Command decode, bus handshake with timeout, and reply sequencing.
  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    byte_cnt_d  = byte_cnt_q;
    timer_d     = timer_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    send_data_d = send_data_q;
    rreq_d      = rreq_q;
    wreq_d      = wreq_q;
    strb_d      = strb_q;
    send_cnt_d  = send_cnt_q;
    tx_start    = 1'b0;
    tx_byte     = send_data_q[31:24];
    case (state_q)
      S_IDLE: if (rx_valid_q) begin
        byte_cnt_d = 2'd3;
        timer_d    = '0;
        if (rx_shift_q == CMD_W || rx_shift_q == CMD_R) begin
          is_write_d = (rx_shift_q == CMD_W);
          state_d    = S_GET_ADDR;
        end else begin
          send_data_d = {NAK, 24'h0};
          send_cnt_d  = 3'd1;
          state_d     = S_SEND;
        end
      end
      S_GET_ADDR, S_GET_DATA: begin
        timer_d = timer_q + 32'd1;
        if (rx_valid_q) begin
          timer_d    = '0;
          byte_cnt_d = byte_cnt_q - 2'd1;
          if (state_q == S_GET_ADDR) addr_d  = {addr_q[23:0], rx_shift_q};
          else                       wdata_d = {wdata_q[23:0], rx_shift_q};
          if (byte_cnt_q == 2'd0) begin
            byte_cnt_d = 2'd3;
            if (state_q == S_GET_DATA) state_d = S_BUS_WRITE;
            else if (is_write_q)       state_d = S_GET_DATA;
            else                       state_d = S_BUS_READ;
          end
        end else if (timer_q == IB_TIMEOUT - 32'd1) begin
          state_d = S_IDLE;  // host lost a byte: resynchronise silently
        end
      end
      S_BUS_WRITE: begin
        if (!wreq_q) begin
          // first cycle here: address/data already stable, raise request now
          wreq_d  = 1'b1;
          strb_d  = 4'hF;
          timer_d = '0;
        end else if (write_response || timer_q == BUS_TO - 32'd1) begin
          wreq_d      = 1'b0;
          strb_d      = '0;
          send_data_d = {(write_response ? ACK : NAK), 24'h0};
          send_cnt_d  = 3'd1;
          state_d     = S_SEND;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_BUS_READ: begin
        if (!rreq_q) begin
          rreq_d  = 1'b1;
          timer_d = '0;
        end else if (read_response) begin
          rreq_d      = 1'b0;
          send_data_d = read_data;
          send_cnt_d  = 3'd4;
          state_d     = S_SEND;
        end else if (timer_q == BUS_TO - 32'd1) begin
          rreq_d      = 1'b0;
          send_data_d = {NAK, 24'h0};
          send_cnt_d  = 3'd1;
          state_d     = S_SEND;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_SEND: if (!tx_busy_q) begin
        if (send_cnt_q != 3'd0) begin
          tx_start    = 1'b1;
          send_data_d = {send_data_q[23:0], 8'h00};
          send_cnt_d  = send_cnt_q - 3'd1;
        end else begin
          state_d = S_IDLE;  // last frame fully on the wire
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign uart_tx       = tx_q;
  assign rw_address    = addr_q;
  assign write_data    = wdata_q;
  assign read_request  = rreq_q;
  assign write_request = wreq_q;
  assign write_strobe  = strb_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_rvsteel_uart_bus_bridge.sv
// Directed bench for the UART bus bridge: host UART driver, bus responder,
// TX decoder checking reply bytes against a queue of expected bytes.
module tb_rvsteel_uart_bus_bridge;

  localparam int CPB    = 16;            // 1600 Hz / 100 baud
  localparam int BUS_TO = 40;
  localparam int IB_TO  = 16 * 10 * CPB;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [31:0] rw_address, read_data, write_data;
  logic        read_request, read_response, write_request, write_response, busy;
  logic [3:0]  write_strobe;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  int          wr_cycles, rd_cycles, proto_err;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_value;
  logic [3:0]  wr_strb;
  logic        resp_en = 1'b1;
  logic        rst_seen;
  logic        prev_rr, prev_wr;
  logic [31:0] prev_addr, prev_wdata;
  logic [7:0]  mon_b;
  logic        mon_stop;

  always #5 clock = ~clock;

  rvsteel_uart_bus_bridge #(
    .CLOCK_FREQUENCY(1600),
    .UART_BAUD_RATE (100),
    .BUS_TIMEOUT    (BUS_TO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .uart_rx       (uart_rx),
    .uart_tx       (uart_tx),
    .rw_address    (rw_address),
    .read_data     (read_data),
    .read_request  (read_request),
    .read_response (read_response),
    .write_data    (write_data),
    .write_strobe  (write_strobe),
    .write_request (write_request),
    .write_response(write_response),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus responder: answers one cycle after seeing a request, when enabled.
  initial begin
    read_response = 1'b0; write_response = 1'b0; read_data = '0;
  end
  always @(posedge clock) begin
    #1;
    read_response  = resp_en && read_request && !read_response;
    write_response = resp_en && write_request && !write_response;
    read_data      = read_response ? rd_value : 32'h0;
  end

  // Bus observer: counts request cycles and flags protocol violations.
  always @(negedge clock) begin
    if (reset_n) begin
      if (read_request && write_request) proto_err++;
      if ((read_request && !prev_rr) || (write_request && !prev_wr))
        if (rw_address !== prev_addr || write_data !== prev_wdata) proto_err++;
      if (write_request) begin
        wr_cycles++; wr_addr = rw_address; wr_data = write_data; wr_strb = write_strobe;
      end
      if (read_request) begin
        rd_cycles++; rd_addr = rw_address;
      end
    end
    prev_rr = read_request; prev_wr = write_request;
    prev_addr = rw_address; prev_wdata = write_data;
  end

  always @(negedge reset_n) rst_seen = 1'b1;

  // UART decoder on uart_tx: pops the scoreboard for every complete frame.
  always begin
    @(negedge uart_tx);
    if (reset_n) begin
      rst_seen = 1'b0;
      repeat (CPB / 2) @(negedge clock);
      if (uart_tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          mon_b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clock);
        mon_stop = uart_tx;
        if (!rst_seen) begin
          check("tx_stop_bit", {31'h0, mon_stop}, 32'h1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL tx_unexpected: observed %h expected no byte", mon_b);
          end else begin
            check("tx_byte", {24'h0, mon_b}, {24'h0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic host_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clock); #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clock); #1;
    end
    uart_rx = stop_bit;
    repeat (CPB) @(posedge clock); #1;
    uart_rx = 1'b1;
    repeat (4) @(posedge clock); #1;
  endtask

  task automatic host_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      host_byte(b);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_reply_done"}, {31'h0, (n < 20000)}, 32'h1);
    repeat (5) @(negedge clock);
  endtask

  task automatic clear_bus();
    wr_cycles = 0; rd_cycles = 0;
    wr_addr = 'x; wr_data = 'x; wr_strb = 'x; rd_addr = 'x;
  endtask

  initial begin
    int n;
    int busy_cycles;
    proto_err = 0;
    rd_value  = '0;
    clear_bus();
    #2 reset_n = 1'b0;
    #21;
    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_read_request", {31'h0, read_request}, 32'h0);
    check("rst_write_request", {31'h0, write_request}, 32'h0);
    check("rst_rw_address", rw_address, 32'h0);
    check("rst_write_data", write_data, 32'h0);
    check("rst_write_strobe", {28'h0, write_strobe}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (5) @(posedge clock); #1;

    // 1: write with immediate response -> ACK
    clear_bus();
    exp_q.push_back(8'h06);
    host_byte(8'h57); host_word(32'h8000_0000); host_word(32'h0000_0041);
    wait_idle("t1");
    check("t1_write_cycles", wr_cycles, 1);
    check("t1_read_cycles", rd_cycles, 0);
    check("t1_address", wr_addr, 32'h8000_0000);
    check("t1_data", wr_data, 32'h0000_0041);
    check("t1_strobe", {28'h0, wr_strb}, 32'hF);
    check("t1_strobe_after", {28'h0, write_strobe}, 32'h0);

    // 2: read returns four bytes MSB first
    clear_bus();
    rd_value = 32'h0000_005A;
    push_word(32'h0000_005A);
    host_byte(8'h52); host_word(32'h8000_0004);
    wait_idle("t2");
    check("t2_read_cycles", rd_cycles, 1);
    check("t2_address", rd_addr, 32'h8000_0004);
    check("t2_write_cycles", wr_cycles, 0);
    check("t2_busy_after", {31'h0, busy}, 32'h0);

    // 3: read with no response -> request held BUS_TIMEOUT cycles, NAK
    clear_bus();
    resp_en = 1'b0;
    exp_q.push_back(8'h15);
    host_byte(8'h52); host_word(32'h0000_1000);
    wait_idle("t3");
    check("t3_request_cycles", rd_cycles, BUS_TO);
    check("t3_address", rd_addr, 32'h0000_1000);
    repeat (200) @(negedge clock);
    check("t3_no_retry", rd_cycles, BUS_TO);
    check("t3_write_cycles", wr_cycles, 0);
    resp_en = 1'b1;

    // 4: unknown command -> NAK, then a normal read
    clear_bus();
    exp_q.push_back(8'h15);
    host_byte(8'h33);
    wait_idle("t4_nak");
    check("t4_nak_no_bus", rd_cycles + wr_cycles, 0);
    rd_value = 32'h1234_5678;
    push_word(32'h1234_5678);
    host_byte(8'h52); host_word(32'h0000_0000);
    wait_idle("t4_read");
    check("t4_read_cycles", rd_cycles, 1);
    check("t4_address", rd_addr, 32'h0000_0000);

    // 5: truncated command -> inter-byte timeout, then a full write
    clear_bus();
    host_byte(8'h57); host_byte(8'h11); host_byte(8'h22);
    repeat (IB_TO / 2) @(negedge clock);
    check("t5_still_waiting", {31'h0, busy}, 32'h1);
    repeat (IB_TO / 2 + 200) @(negedge clock);
    check("t5_timed_out", {31'h0, busy}, 32'h0);
    check("t5_no_bus", rd_cycles + wr_cycles, 0);
    exp_q.push_back(8'h06);
    host_byte(8'h57); host_word(32'h0000_2000); host_word(32'hDEAD_BEEF);
    wait_idle("t5_write");
    check("t5_write_cycles", wr_cycles, 1);
    check("t5_address", wr_addr, 32'h0000_2000);
    check("t5_data", wr_data, 32'hDEAD_BEEF);

    // 6a: reset in the middle of a bus read
    clear_bus();
    resp_en = 1'b0;
    host_byte(8'h52); host_word(32'h0000_3000);
    n = 0;
    while (read_request !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    check("t6_read_started", {31'h0, read_request}, 32'h1);
    #3 reset_n = 1'b0;
    #1;
    check("t6_rd_reset_request", {31'h0, read_request}, 32'h0);
    check("t6_rd_reset_address", rw_address, 32'h0);
    check("t6_rd_reset_busy", {31'h0, busy}, 32'h0);
    check("t6_rd_reset_tx", {31'h0, uart_tx}, 32'h1);
    @(posedge clock); #1 reset_n = 1'b1;
    resp_en = 1'b1;
    repeat (10) @(posedge clock); #1;

    // 6b: reset in the middle of a reply frame
    host_byte(8'h33);
    n = 0;
    while (uart_tx !== 1'b0 && n < 200) begin @(negedge clock); n++; end
    check("t6_tx_started", {31'h0, uart_tx}, 32'h0);
    repeat (3 * CPB) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t6_tx_reset_line", {31'h0, uart_tx}, 32'h1);
    check("t6_tx_reset_busy", {31'h0, busy}, 32'h0);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (200) @(posedge clock); #1;

    // 6c: framing error on a 'W' byte -> no reply, stays idle
    host_byte(8'h57, 1'b0);
    busy_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (busy) busy_cycles++;
    end
    check("t6_frame_err_idle", busy_cycles, 0);
    exp_q.push_back(8'h15);
    host_byte(8'h33);
    wait_idle("t6_recover");

    check("protocol_violations", proto_err, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
